noc_egress_collector: RTL and testbench

// - Receive end of the CGRA ring NoC. Takes 8-bit flits from the last switch's ring output and parses packet headers.
// - Payload of packets addressed to the egress port is buffered. Other packets are dropped.
// - Buffered bytes go to the chip pins under a slow host handshake (ack pin, 2-flop synchronised).
// - Counterpart of the ingress path that pushes ui_in into the ring.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/noc_egress_collector_if.sv | 40 ++++
 rtl/collector_fifo.sv | 50 +++++
 rtl/noc_egress_collector.sv | 159 +++++++++++++++
 tb/tb_noc_egress_collector.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the CGRA ring NoC egress path: flit/header layout,
// collector FSM states and ack synchroniser depth.
package noc_pkg;

  localparam int FLIT_W = 8;

  localparam int HDR_DST_MSB = 7;
  localparam int HDR_DST_LSB = 6;
  localparam int HDR_LEN_MSB = 5;
  localparam int HDR_LEN_LSB = 0;

  localparam int HDR_DST_W = HDR_DST_MSB - HDR_DST_LSB + 1;
  localparam int HDR_LEN_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // Number of flops in the out_ack synchroniser, not counting the history flop.
  localparam int ACK_SYNC_STAGES = 2;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

endpackage

// File: rtl/noc_egress_collector_if.sv
// Ring-side flit handshake plus host-side byte/ack pins of the egress collector.
interface noc_egress_collector_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ack;
  logic [7:0]            pkt_cnt;
  logic [7:0]            drop_cnt;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ack,
    output pkt_cnt,
    output drop_cnt
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ack,
    input  pkt_cnt,
    input  drop_cnt
  );

endinterface

// File: rtl/collector_fifo.sv
// First-word-fall-through payload buffer; head entry is visible while non-empty
// and reads back as zero when empty.
module collector_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/noc_egress_collector.sv
// Receive end of the CGRA ring: parses headers, buffers payload addressed to
// this port, drops the rest, and hands bytes to the host under a synchronised ack.
//
// state   | meaning
// IDLE    | next accepted flit is a header
// PAYLOAD | buffering payload of a packet for this port
// DROP    | discarding payload of a packet for another port
module noc_egress_collector
  import noc_pkg::*;
#(
  parameter int                   DATA_WIDTH = FLIT_W,
  parameter int                   DEPTH      = 8,
  parameter logic [HDR_DST_W-1:0] EGRESS_ID  = 2'd3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  noc_egress_collector_if.slave   io_bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic [HDR_LEN_W-1:0]       r_remaining;
  logic [HDR_LEN_W-1:0]       w_remaining_nxt;
  logic [ACK_SYNC_STAGES-1:0] r_ack_sync;
  logic                       r_ack_hist;
  logic [CNT_W-1:0]           r_pkt_cnt;
  logic [CNT_W-1:0]           r_drop_cnt;

  logic                   w_in_ready;
  logic                   w_xfer;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_ack_rise;
  logic                   w_pkt_inc;
  logic                   w_drop_inc;
  logic [HDR_DST_W-1:0]   w_hdr_dst;
  logic [HDR_LEN_W-1:0]   w_hdr_len;
  logic [DATA_WIDTH:0]    w_wdata;
  logic [DATA_WIDTH:0]    w_rdata;

  assign w_hdr_dst = io_bus.in_data[HDR_DST_MSB:HDR_DST_LSB];
  assign w_hdr_len = io_bus.in_data[HDR_LEN_MSB:HDR_LEN_LSB];

  // Ready depends only on registered state and the registered full flag, so a
  // same-cycle pop never opens the input and in_valid never feeds back.
  assign w_in_ready = (r_state != PAYLOAD) | ~w_full;
  assign w_xfer     = io_bus.in_valid & w_in_ready;

  assign w_ack_rise = r_ack_sync[ACK_SYNC_STAGES-1] & ~r_ack_hist;
  assign w_pop      = w_ack_rise & ~w_empty;

  assign w_wdata = {(r_remaining == HDR_LEN_W'(1)), io_bus.in_data};

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_push          = 1'b0;
    w_pkt_inc       = 1'b0;
    w_drop_inc      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (w_hdr_dst == EGRESS_ID) begin
            if (w_hdr_len != '0) begin
              w_state_nxt     = PAYLOAD;
              w_remaining_nxt = w_hdr_len;
            end else begin
              w_pkt_inc = 1'b1;
            end
          end else begin
            if (w_hdr_len != '0) begin
              w_state_nxt     = DROP;
              w_remaining_nxt = w_hdr_len;
            end else begin
              w_drop_inc = 1'b1;
            end
          end
        end
      end
      PAYLOAD: begin
        if (w_xfer) begin
          w_push          = 1'b1;
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == HDR_LEN_W'(1)) begin
            w_state_nxt = IDLE;
            w_pkt_inc   = 1'b1;
          end
        end
      end
      DROP: begin
        if (w_xfer) begin
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == HDR_LEN_W'(1)) begin
            w_state_nxt = IDLE;
            w_drop_inc  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= '0;
      r_ack_hist <= 1'b0;
    end else begin
      r_ack_sync <= {r_ack_sync[ACK_SYNC_STAGES-2:0], io_bus.out_ack};
      r_ack_hist <= r_ack_sync[ACK_SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pkt_inc)  r_pkt_cnt  <= r_pkt_cnt + 1'b1;
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  collector_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = ~w_empty;
  assign io_bus.out_data  = w_rdata[DATA_WIDTH-1:0];
  assign io_bus.out_last  = w_rdata[DATA_WIDTH];
  assign io_bus.pkt_cnt   = r_pkt_cnt;
  assign io_bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_noc_egress_collector.sv
// Bench for the egress collector: directed scenarios plus randomized traffic
// checked every cycle against a packet-level queue model.
module tb_noc_egress_collector;
  import noc_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_egress_collector_if #(.DATA_WIDTH(8)) bus();

  noc_egress_collector #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .EGRESS_ID  (2'd3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: mode 0 = expecting header, 1 = keeping payload, 2 = discarding payload
  int         m_mode;
  int         m_rem;
  int         m_pkt;
  int         m_drop;
  logic [8:0] m_q[$];
  logic       m_a1, m_a2, m_a3;

  function automatic void model_reset();
    m_mode = 0; m_rem = 0; m_pkt = 0; m_drop = 0;
    m_q.delete();
    m_a1 = 1'b0; m_a2 = 1'b0; m_a3 = 1'b0;
  endfunction

  // {in_ready, out_valid, out_last, out_data, pkt_cnt, drop_cnt}
  function automatic logic [26:0] exp_vec();
    logic [8:0] h;
    logic       rdy;
    h   = (m_q.size() > 0) ? m_q[0] : 9'd0;
    rdy = (m_mode != 1) || (m_q.size() < DEPTH);
    return {rdy, (m_q.size() > 0), h[8], h[7:0], m_pkt[7:0], m_drop[7:0]};
  endfunction

  // One clock edge: inputs are taken as driven now; model follows the
  // behavioural rules (ack rising before edge N pops at N+2).
  task automatic step(output bit xf);
    logic       rdy, pp, ack_now;
    logic [7:0] d;
    rdy     = (m_mode != 1) || (m_q.size() < DEPTH);
    xf      = bus.in_valid && rdy;
    d       = bus.in_data;
    ack_now = bus.out_ack;
    pp      = m_a2 && !m_a3 && (m_q.size() > 0);
    @(posedge clk);
    cyc++;
    if (pp) void'(m_q.pop_front());
    m_a3 = m_a2; m_a2 = m_a1; m_a1 = ack_now;
    if (xf) begin
      case (m_mode)
        0: begin
          if (d[7:6] == 2'd3) begin
            if (d[5:0] != 0) begin m_mode = 1; m_rem = d[5:0]; end
            else m_pkt++;
          end else begin
            if (d[5:0] != 0) begin m_mode = 2; m_rem = d[5:0]; end
            else m_drop++;
          end
        end
        1: begin
          m_q.push_back({(m_rem == 1), d});
          m_rem--;
          if (m_rem == 0) begin m_mode = 0; m_pkt++; end
        end
        default: begin
          m_rem--;
          if (m_rem == 0) begin m_mode = 0; m_drop++; end
        end
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.out_ack  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [26:0] obs;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC5;
    bus.out_ack  = 1'b1;
    rst_n = 1'b0;
    #3;
    obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt, bus.drop_cnt};
    total++;
    if (obs !== {1'b1, 26'd0}) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", obs, {1'b1, 26'd0});
    end
    do_reset();
    obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt, bus.drop_cnt};
    total++;
    if (obs !== {1'b1, 26'd0}) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", obs, {1'b1, 26'd0});
    end
  endtask

  task automatic test_accept();
    logic [7:0] flits[4] = '{8'hC3, 8'h11, 8'h22, 8'h33};
    logic [8:0] heads[3] = '{9'h022, 9'h133, 9'h000};
    bit xf;
    logic [26:0] obs;
    do_reset();
    foreach (flits[i]) begin
      bus.in_valid = 1'b1; bus.in_data = flits[i];
      step(xf);
      obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt, bus.drop_cnt};
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL accept_fill cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt} !== {1'b1, 1'b0, 8'h11, 8'd1}) begin
      bad++; $display("FAIL accept_head got=%b/%b/%h pkt=%0d exp=1/0/11 pkt=1",
                      bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt);
    end
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 6; c++) begin
        bus.out_ack = (c < 3);
        step(xf);
        obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt, bus.drop_cnt};
        total++;
        if (obs !== exp_vec()) begin
          bad++; $display("FAIL accept_ack cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
        end
      end
      total++;
      if ({bus.out_valid, bus.out_last, bus.out_data} !== {(p < 2), heads[p]}) begin
        bad++; $display("FAIL accept_pop%0d got=%b/%b/%h exp=%b/%h", p,
                        bus.out_valid, bus.out_last, bus.out_data, (p < 2), heads[p]);
      end
    end
  endtask

  task automatic test_drop_and_len0();
    logic [7:0] flits[3] = '{8'h42, 8'hA5, 8'h5A};
    bit xf;
    do_reset();
    foreach (flits[i]) begin
      bus.in_valid = 1'b1; bus.in_data = flits[i];
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++; $display("FAIL drop_ready got=%b exp=1", bus.in_ready);
      end
      step(xf);
    end
    bus.in_valid = 1'b0;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.pkt_cnt, bus.drop_cnt} !== {1'b1, 1'b0, 8'd0, 8'd1}) begin
      bad++; $display("FAIL drop_result got=rdy%b v%b pkt%0d drop%0d exp=rdy1 v0 pkt0 drop1",
                      bus.in_ready, bus.out_valid, bus.pkt_cnt, bus.drop_cnt);
    end
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 8'hC0;
    step(xf);
    bus.in_valid = 1'b0;
    step(xf);
    total++;
    if ({bus.in_ready, bus.out_valid, bus.pkt_cnt, bus.drop_cnt} !== {1'b1, 1'b0, 8'd1, 8'd0}) begin
      bad++; $display("FAIL len0_result got=rdy%b v%b pkt%0d drop%0d exp=rdy1 v0 pkt1 drop0",
                      bus.in_ready, bus.out_valid, bus.pkt_cnt, bus.drop_cnt);
    end
  endtask

  // Packet longer than the buffer: backpressure, then drain one per ack rise.
  task automatic test_full();
    bit xf;
    int sent = 0;
    int budget = 400;
    logic [26:0] obs;
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 8'hCA;
    while ((sent < 11 || m_q.size() > 0) && budget > 0) begin
      budget--;
      bus.out_ack = (cyc % 6) < 3 && sent >= 11 + 0 ? 1'b1 : ((cyc % 6) < 3 && budget < 380);
      step(xf);
      if (xf) begin
        sent++;
        bus.in_data = 8'(($urandom_range(0, 255)));
        if (sent >= 11) bus.in_valid = 1'b0;
      end
      obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt, bus.drop_cnt};
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL full_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (budget == 385) begin
        total++;
        if (bus.in_ready !== 1'b0) begin
          bad++; $display("FAIL full_backpressure got=%b exp=0", bus.in_ready);
        end
      end
    end
    bus.out_ack = 1'b0;
    total++;
    if (budget == 0) begin
      bad++; $display("FAIL full_timeout sent=%0d left=%0d", sent, m_q.size());
    end
    total++;
    if ({bus.out_valid, bus.pkt_cnt} !== {1'b0, 8'd1}) begin
      bad++; $display("FAIL full_done got=v%b pkt%0d exp=v0 pkt1", bus.out_valid, bus.pkt_cnt);
    end
  endtask

  // Two back-to-back packets with ack toggling every 4 cycles.
  task automatic test_stream();
    logic [7:0] flits[$];
    logic [26:0] obs;
    bit xf;
    int idx = 0;
    int budget = 300;
    int popped = 0;
    int last_pos[$];
    do_reset();
    flits.push_back(8'hC5);
    for (int i = 0; i < 5; i++) flits.push_back(8'(8'h10 + i));
    flits.push_back(8'hC3);
    for (int i = 0; i < 3; i++) flits.push_back(8'(8'h80 + i));
    while ((idx < flits.size() || bus.out_valid) && budget > 0) begin
      budget--;
      bus.in_valid = (idx < flits.size());
      bus.in_data  = (idx < flits.size()) ? flits[idx] : 8'h00;
      bus.out_ack  = ((cyc / 4) % 2 == 1);
      if (bus.out_valid && m_a2 && !m_a3) begin
        popped++;
        if (bus.out_last) last_pos.push_back(popped);
      end
      step(xf);
      if (xf) idx++;
      obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt, bus.drop_cnt};
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL stream_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    bus.in_valid = 1'b0; bus.out_ack = 1'b0;
    total++;
    if (budget == 0 || bus.pkt_cnt !== 8'd2) begin
      bad++; $display("FAIL stream_done got=pkt%0d budget=%0d exp=pkt2", bus.pkt_cnt, budget);
    end
    total++;
    if (popped != 8 || last_pos.size() != 2 || last_pos[0] != 5 || last_pos[1] != 8) begin
      bad++; $display("FAIL stream_last got=popped%0d nlast%0d exp=popped8 last@5,8",
                      popped, last_pos.size());
    end
  endtask

  // Random packets, random in_valid and a randomly toggling host ack.
  task automatic test_random();
    logic [7:0] flits[$];
    logic [26:0] obs;
    bit xf;
    int idx = 0;
    int budget = 6000;
    int len;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(0, 12);
      flits.push_back({(($urandom_range(0, 3) == 0) ? 2'(($urandom_range(0, 2))) : 2'd3), 6'(len)});
      for (int i = 0; i < len; i++) flits.push_back(8'($urandom_range(0, 255)));
    end
    do_reset();
    while ((idx < flits.size() || m_q.size() > 0) && budget > 0) begin
      budget--;
      bus.in_valid = (idx < flits.size()) && ($urandom_range(0, 9) < 7);
      bus.in_data  = (idx < flits.size()) ? flits[idx] : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) bus.out_ack = ~bus.out_ack;
      step(xf);
      if (xf) idx++;
      obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt, bus.drop_cnt};
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    bus.in_valid = 1'b0; bus.out_ack = 1'b0;
    total++;
    if (budget == 0) begin
      bad++; $display("FAIL random_timeout idx=%0d left=%0d", idx, m_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit xf;
    logic [26:0] obs;
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 8'hC9;
    step(xf);
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'(8'h60 + i);
      step(xf);
    end
    bus.in_valid = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_data, bus.pkt_cnt} !== {1'b1, 8'h60, 8'd0}) begin
      bad++; $display("FAIL mid_before got=v%b d%h pkt%0d exp=v1 d60 pkt0",
                      bus.out_valid, bus.out_data, bus.pkt_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.pkt_cnt, bus.drop_cnt} !== {1'b1, 1'b0, 24'd0}) begin
      bad++; $display("FAIL mid_async got=rdy%b v%b d%h pkt%0d drop%0d exp=rdy1 v0 d00 pkt0 drop0",
                      bus.in_ready, bus.out_valid, bus.out_data, bus.pkt_cnt, bus.drop_cnt);
    end
    model_reset();
    #1 rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'hC2;
    step(xf);
    bus.in_data = 8'h7E; step(xf);
    bus.in_data = 8'h7F; step(xf);
    bus.in_valid = 1'b0;
    obs = {bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, bus.pkt_cnt, bus.drop_cnt};
    total++;
    if (obs !== {1'b1, 1'b1, 1'b0, 8'h7E, 8'd1, 8'd0}) begin
      bad++; $display("FAIL mid_after got=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 8'h7E, 8'd1, 8'd0});
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.out_ack  = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_accept();
    test_drop_and_len0();
    test_full();
    test_stream();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
